// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: FSM states, Gray states, start-up length.
// Latency: none (constants and a pure function).
// Backpressure: none; the encoder cannot be stalled.
package quad_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Gray states written as {A, B}
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

  // Cycles spent in INIT after reset release
  localparam int INIT_CYCLES = 3;

  // Next state in the up (A leads) direction: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] gray_up_next(input logic [1:0] s);
    logic [1:0] n;
    n = S10;
    case (s)
      S00:     n = S10;
      S10:     n = S11;
      S11:     n = S01;
      default: n = S00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder-side bundle: enable plus raw A/B in, direction/step/error strobes out.
// Latency: none (wiring only).
// Backpressure: none; outputs are strobes the consumer must take as they come.
interface quad_decoder_if;
  logic en;
  logic a_in;
  logic b_in;
  logic ud;
  logic step;
  logic err;

  modport master (output en, output a_in, output b_in,
                  input  ud, input  step, input  err);
  modport slave  (input  en, input  a_in, input  b_in,
                  output ud, output step, output err);
endinterface

// File: rtl/quad_glitch_filter.sv
// One encoder channel: 2-flop synchroniser then a hold-time glitch filter with INIT bypass.
// Latency: 2 cycles to sync, FILTER_LEN+1 more before a clean level is accepted.
// Backpressure: none; pulses shorter than the hold time are discarded by design.
module quad_glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic bypass,
  input  logic raw,
  output logic sync,
  output logic level
);

  localparam logic [3:0] LEN = 4'(FILTER_LEN);

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_len
    $error("FILTER_LEN must be in 1..15");
  end

  logic       meta;
  logic [3:0] cnt;

  // Two-flop synchroniser; raw is touched by nothing else
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Accept a new level only after it has differed from the current one for LEN cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= 1'b0;
      cnt   <= 4'd0;
    end else if (bypass) begin
      level <= sync;
      cnt   <= 4'd0;
    end else if (sync == level) begin
      cnt <= 4'd0;
    end else if (cnt == LEN) begin
      level <= sync;
      cnt   <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B Gray decode into registered ud/step/err strobes.
// Latency: a clean edge sampled at edge N pulses step in the cycle after edge N+FILTER_LEN+3.
// Backpressure: none; inputs faster than one change per FILTER_LEN+1 cycles are treated as noise.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int RES        = 4
) (
  input logic          clk,
  input logic          rst,
  quad_decoder_if.slave bus
);

  if (!(RES == 1 || RES == 2 || RES == 4)) begin : g_bad_res
    $error("RES must be 1, 2 or 4");
  end

  logic [0:0] state;
  logic [1:0] init_cnt;
  logic       bypass;
  logic       a_sync, b_sync;
  logic       a_lvl, b_lvl;
  logic [1:0] cur, prev;
  logic       up_cand, dn_cand, both_chg, gate;
  logic       ud_q, step_q, err_q;

  assign bypass = (state == ST_INIT);
  assign cur    = {a_lvl, b_lvl};

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .bypass(bypass), .raw(bus.a_in), .sync(a_sync), .level(a_lvl)
  );

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .bypass(bypass), .raw(bus.b_in), .sync(b_sync), .level(b_lvl)
  );

  // Start-up FSM: hold INIT for INIT_CYCLES edges after reset release, then RUN until reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= 2'd0;
    end else if (state == ST_INIT) begin
      if (init_cnt == 2'(INIT_CYCLES - 1)) begin
        state <= ST_RUN;
      end else begin
        init_cnt <= init_cnt + 2'd1;
      end
    end
  end

  // Classify the cur/prev pair and apply the resolution gate
  always_comb begin
    up_cand  = 1'b0;
    dn_cand  = 1'b0;
    both_chg = 1'b0;
    gate     = 1'b0;
    if (cur != prev) begin
      up_cand  = (cur == gray_up_next(prev));
      dn_cand  = (prev == gray_up_next(cur));
      both_chg = ((cur ^ prev) == 2'b11);
    end
    case (RES)
      1:       gate = ~prev[1] & cur[1];
      2:       gate = prev[1] ^ cur[1];
      default: gate = 1'b1;
    endcase
  end

  // Registered outputs; prev tracks cur every cycle even when disabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev   <= S00;
      ud_q   <= 1'b1;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == ST_INIT) begin
        // The filters load sync this same edge, so loading prev from sync
        // leaves prev equal to the filtered state on entry to RUN.
        prev <= {a_sync, b_sync};
      end else begin
        prev <= cur;
        if (bus.en) begin
          if (both_chg) begin
            err_q <= 1'b1;
          end else if ((up_cand || dn_cand) && gate) begin
            step_q <= 1'b1;
            ud_q   <= up_cand;
          end
        end
      end
    end
  end

  assign bus.ud   = ud_q;
  assign bus.step = step_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench: three decoders (RES 4/2/1) share one random encoder stream.
// Latency: expected pulses are due FILTER_LEN+4 monitor cycles after the input drive.
// Backpressure: none; the scoreboard flags missing, extra or mistimed pulses.
module tb_quad_decoder;

  localparam int FL = 4;

  typedef struct {
    int dut;
    bit is_err;
    bit ud;
    int due;
  } exp_t;

  logic clk;
  logic rst;
  logic en_s, a_s, b_s;

  quad_decoder_if if4 ();
  quad_decoder_if if2 ();
  quad_decoder_if if1 ();

  assign if4.en = en_s;  assign if4.a_in = a_s;  assign if4.b_in = b_s;
  assign if2.en = en_s;  assign if2.a_in = a_s;  assign if2.b_in = b_s;
  assign if1.en = en_s;  assign if1.a_in = a_s;  assign if1.b_in = b_s;

  quad_decoder #(.FILTER_LEN(FL), .RES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  quad_decoder #(.FILTER_LEN(FL), .RES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  quad_decoder #(.FILTER_LEN(FL), .RES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         mcyc  = 0;
  bit         exp_ud[3];
  logic [3:0] tb_cnt = 4'd0;
  logic [1:0] mstate;
  int         res_of[3] = '{4, 2, 1};

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, mcyc);
    end
  endtask

  // Position of a {A,B} state around the up cycle 00,10,11,01
  function automatic int gpos(input logic [1:0] s);
    logic [1:0] tab[4];
    tab = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) if (tab[i] == s) return i;
    return 0;
  endfunction

  function automatic logic [1:0] gstate(input int p);
    logic [1:0] tab[4];
    tab = '{2'b00, 2'b10, 2'b11, 2'b01};
    return tab[((p % 4) + 4) % 4];
  endfunction

  // Monitor: samples 1 time unit after each rising edge
  initial begin : monitor
    bit st[3], er[3], u[3];
    int idx;
    exp_ud = '{1'b1, 1'b1, 1'b1};
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      st = '{if4.step, if2.step, if1.step};
      er = '{if4.err,  if2.err,  if1.err};
      u  = '{if4.ud,   if2.ud,   if1.ud};
      if (!rst) begin
        sb.delete();
        for (int r = 0; r < 3; r++) begin
          exp_ud[r] = 1'b1;
          chk(u[r] == 1'b1, "reset_ud", int'(u[r]), 1);
          chk(st[r] == 1'b0, "reset_step", int'(st[r]), 0);
          chk(er[r] == 1'b0, "reset_err", int'(er[r]), 0);
        end
      end else begin
        for (int r = 0; r < 3; r++) begin
          if (st[r] && er[r]) chk(1'b0 == (st[r] && er[r]), "step_err_overlap", r, 0);
          if (st[r] || er[r]) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
              if (idx < 0 && sb[i].dut == r) idx = i;
            end
            chk(idx >= 0, "unexpected_pulse", r, -1);
            if (idx >= 0) begin
              chk(sb[idx].due == mcyc, "pulse_time", mcyc, sb[idx].due);
              chk(er[r] == sb[idx].is_err, "pulse_kind_err", int'(er[r]), int'(sb[idx].is_err));
              if (!sb[idx].is_err) exp_ud[r] = sb[idx].ud;
              sb.delete(idx);
            end
            if (r == 0 && st[0]) tb_cnt = u[0] ? tb_cnt + 4'd1 : tb_cnt - 4'd1;
          end
          chk(u[r] == exp_ud[r], "ud_level", int'(u[r]), int'(exp_ud[r]));
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].due < mcyc) begin
            chk(sb[i].due >= mcyc, "missed_pulse", sb[i].dut, sb[i].due);
            sb.delete(i);
          end
        end
      end
    end
  end

  // Drive a new encoder state at a falling edge and record the expected reaction
  task automatic seg(input logic [1:0] nxt, input int hold);
    int  d;
    bit  take;
    exp_t e;
    if (en_s && nxt != mstate) begin
      d = (gpos(nxt) - gpos(mstate) + 4) % 4;
      for (int r = 0; r < 3; r++) begin
        e.dut = r;
        e.due = mcyc + FL + 4;
        if (d == 2) begin
          e.is_err = 1'b1;
          e.ud     = 1'b0;
          sb.push_back(e);
        end else begin
          take = (res_of[r] == 4) ||
                 (res_of[r] == 2 && nxt[1] != mstate[1]) ||
                 (res_of[r] == 1 && !mstate[1] && nxt[1]);
          if (take) begin
            e.is_err = 1'b0;
            e.ud     = (d == 1);
            sb.push_back(e);
          end
        end
      end
    end
    a_s    = nxt[1];
    b_s    = nxt[0];
    mstate = nxt;
    repeat (hold) @(negedge clk);
  endtask

  task automatic glitch(input bit ch_a, input int g, input int hold);
    if (ch_a) a_s = ~a_s; else b_s = ~b_s;
    repeat (g) @(negedge clk);
    a_s = mstate[1];
    b_s = mstate[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin : stim
    int k, hold;
    rst = 1'b0; en_s = 1'b1; a_s = 1'b1; b_s = 1'b1; mstate = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);

    // walk to 00, then one full up rotation
    seg(2'b01, 12); seg(2'b00, 12);
    seg(2'b10, 10); seg(2'b11, 10); seg(2'b01, 10); seg(2'b00, 10);
    // down rotation, counter preset to 5
    tb_cnt = 4'd5;
    seg(2'b01, 12); seg(2'b11, 12); seg(2'b10, 12); seg(2'b00, 12);
    chk(tb_cnt == 4'd1, "counter_after_down", int'(tb_cnt), 1);
    // glitch and illegal transition
    glitch(1'b1, 3, 12);
    seg(2'b11, 12); seg(2'b00, 12);
    // disabled transitions, re-enable, then a normal one
    en_s = 1'b0;
    seg(2'b10, 12); seg(2'b11, 12);
    en_s = 1'b1;
    repeat (12) @(negedge clk);
    seg(2'b01, 12);
    // reset mid-rotation with a transition in flight
    seg(2'b00, 3);
    reset_pulse();

    for (int i = 0; i < 160; i++) begin
      k    = int'($urandom_range(0, 9));
      hold = int'($urandom_range(10, 14));
      if (i % 55 == 30) begin
        seg(gstate(gpos(mstate) + 1), int'($urandom_range(2, 6)));
        reset_pulse();
      end else if (k <= 6) begin
        if (k == 0) en_s = ~en_s;
        seg(gstate(gpos(mstate) + (($urandom_range(0, 1) == 1) ? 1 : 3)), hold);
      end else if (k <= 8) begin
        glitch($urandom_range(0, 1) == 1, int'($urandom_range(1, 3)), hold);
      end else begin
        seg(~mstate, hold);
      end
    end

    en_s = 1'b1;
    repeat (20) @(negedge clk);
    chk(sb.size() == 0, "queue_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
